// File: rtl/fir_tap_sequencer_pkg.sv
// Shared widths, defaults and FSM state type for the FIR tap sequencer slice.
package fir_tap_sequencer_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COEF_W  = 8;
    localparam int DEF_NTAPS   = 8;
    localparam int DEF_DEPTH   = 16;
    localparam int COEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LATCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fir_tap_sequencer_q17_mult_sat.sv
// Combinational signed sample x Q1.(COEF_W-1) coefficient multiply with
// arithmetic rescale (floor) and saturation back to DATA_W bits.
module q17_mult_sat #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 8
) (
    input  logic [DATA_W-1:0] i_sample,
    input  logic [COEF_W-1:0] i_coef,
    output logic [DATA_W-1:0] o_product
);

    localparam int PW = DATA_W + COEF_W;

    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] w_shift;
    logic                 w_ovf;

    assign w_prod  = PW'($signed(i_sample)) * PW'($signed(i_coef));
    assign w_shift = w_prod >>> (COEF_W - 1);

    // In range only when every bit above the result sign matches it.
    assign w_ovf = ~(&w_shift[PW-1:DATA_W-1]) & (|w_shift[PW-1:DATA_W-1]);

    always_comb begin
        o_product = w_shift[DATA_W-1:0];
        if (w_ovf) begin
            o_product = w_shift[PW-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                      : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Per-ADC-sample FIR tap streamer: captures a sample into a circular delay line
// and emits NTAPS weighted taps, one per clk, to the downstream accumulator.
module fir_tap_sequencer
    import fir_tap_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter int NTAPS  = DEF_NTAPS,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   adc_clock,
    input  logic [DATA_W-1:0]      sample_in,
    input  logic                   coef_wr_en,
    input  logic [COEF_ADDR_W-1:0] coef_wr_addr,
    input  logic [COEF_W-1:0]      coef_wr_data,
    output logic [DATA_W-1:0]      tap_product,
    output logic                   tap_valid,
    output logic                   frame_done,
    output logic                   busy,
    output logic                   overrun
);

    localparam int AW = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_next;
    logic              r_s1, r_s2, r_s3;
    logic              w_fall;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_tap_idx;
    logic [AW-1:0]     w_rd_idx;
    logic              w_last_tap;
    logic [DATA_W-1:0] r_buf  [DEPTH];
    logic [COEF_W-1:0] r_coef [DEPTH];
    logic [DATA_W-1:0] w_mult;
    logic [DATA_W-1:0] r_product;
    logic              r_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= adc_clock;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_fall     = r_s3 & ~r_s2;
    assign w_last_tap = (r_tap_idx == AW'(NTAPS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_fall) w_next = ST_LATCH;
            ST_LATCH: w_next = ST_RUN;
            ST_RUN:   if (w_last_tap) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_tap_idx <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                ST_LATCH: begin
                    r_buf[r_wr_ptr] <= sample_in;
                    r_tap_idx       <= '0;
                end
                ST_RUN: begin
                    r_tap_idx <= r_tap_idx + 1'b1;
                    if (w_last_tap) r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Entries at or above NTAPS are never written and stay zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_coef[i] <= '0;
            r_coef[0] <= {1'b0, {(COEF_W-1){1'b1}}};
        end else if (coef_wr_en && (32'(coef_wr_addr) < NTAPS)) begin
            r_coef[AW'(coef_wr_addr)] <= coef_wr_data;
        end
    end

    assign w_rd_idx = r_wr_ptr - r_tap_idx;

    q17_mult_sat #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W)
    ) u_mult (
        .i_sample (r_buf[w_rd_idx]),
        .i_coef   (r_coef[r_tap_idx]),
        .o_product(w_mult)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_product <= '0;
        end else begin
            r_valid   <= (r_state == ST_RUN);
            r_product <= (r_state == ST_RUN) ? w_mult : '0;
        end
    end

    assign tap_product = r_product;
    assign tap_valid   = r_valid;
    assign frame_done  = (r_state == ST_DONE);
    assign busy        = (r_state != ST_IDLE);
    assign overrun     = w_fall & (r_state != ST_IDLE);

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Self-checking bench for fir_tap_sequencer: table-driven product vectors,
// hand sequences for corner cases, and random frames against a sample-history model.
module tb_fir_tap_sequencer;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int NTAPS  = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              adc_clock;
    logic [DATA_W-1:0] sample_in;
    logic              coef_wr_en;
    logic [3:0]        coef_wr_addr;
    logic [COEF_W-1:0] coef_wr_data;
    logic [DATA_W-1:0] tap_product;
    logic              tap_valid;
    logic              frame_done;
    logic              busy;
    logic              overrun;

    int errors = 0;
    int checks = 0;

    // Model: newest-first history of accepted samples, plus coefficient table.
    logic [15:0] hist[$];
    logic [7:0]  mcoef[NTAPS];

    typedef struct {
        logic [15:0] smp;
        logic [7:0]  c0;
        logic [15:0] exp_tap0;
    } vec_t;

    fir_tap_sequencer #(
        .DATA_W(DATA_W),
        .COEF_W(COEF_W),
        .NTAPS (NTAPS),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .adc_clock   (adc_clock),
        .sample_in   (sample_in),
        .coef_wr_en  (coef_wr_en),
        .coef_wr_addr(coef_wr_addr),
        .coef_wr_data(coef_wr_data),
        .tap_product (tap_product),
        .tap_valid   (tap_valid),
        .frame_done  (frame_done),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: floor(s*c / 2^(COEF_W-1)) clamped to the signed DATA_W range.
    function automatic logic [15:0] ref_prod(input logic [15:0] s, input logic [7:0] c);
        longint p, q;
        p = longint'($signed(s)) * longint'($signed(c));
        q = p / 128;
        if (p < 0 && (p % 128) != 0) q = q - 1;
        if (q > 32767) q = 32767;
        if (q < -32768) q = -32768;
        return q[15:0];
    endfunction

    task automatic model_reset();
        hist = {};
        repeat (DEPTH) hist.push_back(16'h0);
        for (int k = 0; k < NTAPS; k++) mcoef[k] = 8'h00;
        mcoef[0] = 8'h7F;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [7:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        tick();
        coef_wr_en = 1'b0;
        if (int'(a) < NTAPS) mcoef[a] = d;
    endtask

    // One frame: drop adc_clock, watch up to 25 cycles, compare every observable.
    // ovr: re-raise and drop adc_clock so a second fall lands mid-frame.
    // wr_k >= 0: write coef[wr_k] during the RUN cycle that reads tap wr_k.
    task automatic run_frame(input logic [15:0] smp, input bit ovr,
                             input int wr_k, input logic [7:0] wr_val);
        logic [15:0] e[NTAPS];
        int first, nv, nd, nov;
        bit zero_bad, done_bad;
        first = -1; nv = 0; nd = 0; nov = 0; zero_bad = 0; done_bad = 0;
        for (int k = 0; k < NTAPS; k++)
            e[k] = ref_prod((k == 0) ? smp : hist[k-1], mcoef[k]);
        sample_in = smp;
        adc_clock = 1'b0;
        for (int t = 1; t <= 25; t++) begin
            tick();
            if (tap_valid) begin
                if (first < 0) first = t;
                if (t - first < NTAPS)
                    chk($sformatf("tap%0d", t - first), tap_product, e[t-first]);
                nv++;
            end else if (tap_product != '0) begin
                zero_bad = 1;
            end
            if (frame_done) begin
                nd++;
                if (!tap_valid || (t - first) != NTAPS - 1) done_bad = 1;
            end
            if (overrun) nov++;
            if (ovr && t == 1) adc_clock = 1'b1;
            if (ovr && t == 3) adc_clock = 1'b0;
            if (wr_k >= 0 && t == 4 + wr_k) begin
                coef_wr_en   = 1'b1;
                coef_wr_addr = 4'(wr_k);
                coef_wr_data = wr_val;
            end
            if (wr_k >= 0 && t == 5 + wr_k) coef_wr_en = 1'b0;
        end
        chk("latency_drop_to_valid", first, 5);
        chk("valid_count", nv, NTAPS);
        chk("frame_done_count", nd, 1);
        chk("frame_done_in_last_tap", done_bad, 0);
        chk("product_zero_when_invalid", zero_bad, 0);
        chk("overrun_pulses", nov, ovr ? 1 : 0);
        chk("idle_after_frame", busy, 0);
        if (wr_k >= 0) mcoef[wr_k] = wr_val;
        hist.push_front(smp);
        void'(hist.pop_back());
        adc_clock = 1'b1;
        repeat (3) tick();
    endtask

    initial begin
        vec_t vecs[7];
        int   vcnt;
        bit   saw_valid;

        vecs[0] = '{16'h4000, 8'h7F, 16'h3F80};
        vecs[1] = '{16'h8000, 8'h80, 16'h7FFF};
        vecs[2] = '{16'h7FFF, 8'h80, 16'h8001};
        vecs[3] = '{16'hFFFF, 8'h01, 16'hFFFF};
        vecs[4] = '{16'h1234, 8'h40, 16'h091A};
        vecs[5] = '{16'h8000, 8'h7F, 16'h8100};
        vecs[6] = '{16'hFFFF, 8'h7F, 16'hFFFF};

        // Reset with random inputs
        rst_n = 1'b0;
        coef_wr_en = 1'b0; coef_wr_addr = '0; coef_wr_data = '0;
        adc_clock = 1'b1; sample_in = '0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            adc_clock    = 1'($urandom);
            sample_in    = 16'($urandom);
            coef_wr_en   = 1'($urandom);
            coef_wr_addr = 4'($urandom);
            coef_wr_data = 8'($urandom);
            tick();
            chk("reset_outputs_zero",
                {tap_product, tap_valid, frame_done, busy, overrun}, 0);
        end
        adc_clock = 1'b1; coef_wr_en = 1'b0; sample_in = '0;
        rst_n = 1'b1;
        saw_valid = 0;
        repeat (100) begin
            tick();
            if (tap_valid || busy) saw_valid = 1;
        end
        chk("quiet_after_reset", saw_valid, 0);

        // Table: coef0 only, single-tap products including saturation/floor
        for (int v = 0; v < 7; v++) begin
            write_coef(4'd0, vecs[v].c0);
            for (int k = 1; k < NTAPS; k++) write_coef(4'(k), 8'h00);
            chk($sformatf("vec%0d_model_tap0", v), ref_prod(vecs[v].smp, vecs[v].c0),
                vecs[v].exp_tap0);
            run_frame(vecs[v].smp, 1'b0, -1, 8'h00);
        end

        // Delay taps: coef0 = coef3 = 0.5
        for (int k = 0; k < NTAPS; k++) write_coef(4'(k), (k == 0 || k == 3) ? 8'h40 : 8'h00);
        run_frame(16'h1000, 1'b0, -1, 8'h00);
        run_frame(16'h0000, 1'b0, -1, 8'h00);
        run_frame(16'h0000, 1'b0, -1, 8'h00);
        chk("delay_tap0_expect", ref_prod(16'h2000, mcoef[0]), 16'h1000);
        chk("delay_tap3_expect", ref_prod(hist[2], mcoef[3]), 16'h0800);
        run_frame(16'h2000, 1'b0, -1, 8'h00);

        // Ignored coefficient addresses, overrun and mid-frame coefficient writes
        write_coef(4'd9, 8'h55);
        write_coef(4'd15, 8'h7F);
        run_frame(16'h3000, 1'b1, -1, 8'h00);
        run_frame(16'h0100, 1'b0, 2, 8'h7F);
        run_frame(16'h0200, 1'b0, -1, 8'h00);

        // Random frames, enough to wrap the write pointer
        for (int f = 0; f < 24; f++) begin
            repeat ($urandom_range(1, 2)) write_coef(4'($urandom_range(0, 15)), 8'($urandom));
            run_frame(16'($urandom), (f % 5) == 2,
                      ((f % 4) == 1) ? int'($urandom_range(0, NTAPS - 1)) : -1, 8'($urandom));
        end

        // Reset in the middle of RUN (tap 4 showing)
        sample_in = 16'h5555;
        adc_clock = 1'b0;
        repeat (9) tick();
        chk("midrun_valid_before_reset", tap_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrun_async_drop", {tap_product, tap_valid, frame_done, busy}, 0);
        vcnt = 0;
        repeat (3) begin
            tick();
            if (frame_done || tap_valid) vcnt++;
        end
        chk("midrun_no_done", vcnt, 0);
        adc_clock = 1'b1;
        rst_n = 1'b1;
        model_reset();
        repeat (3) tick();
        for (int k = 0; k < NTAPS; k++) write_coef(4'(k), 8'h40);
        run_frame(16'h2000, 1'b0, -1, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
